// File: rtl/ps2_pkg.sv
// PS/2 keyboard transmitter shared definitions: FSM state codes, frame geometry, framing helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ps2_pkg;

    // FSM state codes
    typedef logic [2:0] ps2_state_t;
    localparam ps2_state_t ST_IDLE    = 3'd0;
    localparam ps2_state_t ST_BIT_HI  = 3'd1;
    localparam ps2_state_t ST_BIT_LO  = 3'd2;
    localparam ps2_state_t ST_GAP     = 3'd3;
    localparam ps2_state_t ST_INHIBIT = 3'd4;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    // inter-frame idle, counted in PS/2 clock half-periods
    localparam int PS2_GAP_HALVES = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Wire order is LSB first: bit 0 is the start bit, bit 10 the stop bit.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count and full/empty flags.
// Latency: pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports: clk/reset_n; push/push_dat write side; pop/pop_dat read side
// (pop_dat shows the head word, pop advances past it); full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Flags are computed from the next count so they are registered yet
    // never lag the occupancy they describe. Pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side keyboard transmitter: bytes in on valid/ready, 11-bit frames out on ps2_clk/ps2_data.
// Latency: byte written into an empty idle FIFO at edge N drives the start bit after edge N+2; frame = 22*HALF_DIV cycles + 2*HALF_DIV gap.
// Backpressure: in_ready low while the FIFO is full; host_inhibit aborts a frame, which is resent from the holder.
//
// Ports: clk, reset_n (async, active low); in_data/in_valid/in_ready byte
// stream; host_inhibit (synchronous host clock-hold); ps2_clk/ps2_data
// (1 = released); busy (frame running or bytes pending); tx_done (1-cycle
// pulse on frame completion).
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int HALF_DIV   = 1000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       host_inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       tx_done
);

    localparam int               CW        = $clog2(HALF_DIV);
    localparam logic [CW-1:0]    HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(PS2_GAP_HALVES - 1);

    ps2_state_t                     state;
    logic [CW-1:0]                  half_cnt;
    logic [3:0]                     bit_idx;
    logic [PS2_FRAME_BITS-2:0]      shreg;
    logic [7:0]                     hold_dat;
    logic                           hold_vld;
    logic                           pend_q;

    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_pop;
    logic [7:0]                     fifo_dat;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    logic                           half_end;
    logic                           start;
    logic                           abort;
    logic [7:0]                     frame_src;
    logic [PS2_FRAME_BITS-1:0]      frame_w;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (in_valid),
        .push_dat (in_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign in_ready = ~fifo_full;

    assign half_end = (half_cnt == HALF_LAST);

    // pend_q is a registered "something to send" flag, so IDLE launches one
    // cycle after the byte lands in the FIFO. The live check guards the pop.
    assign start = (state == ST_IDLE) && pend_q && !host_inhibit &&
                   (hold_vld || !fifo_empty);

    // A byte waiting in the holder (aborted frame) goes out before the FIFO.
    assign fifo_pop  = start && !hold_vld;
    assign frame_src = hold_vld ? hold_dat : fifo_dat;
    assign frame_w   = ps2_frame(frame_src);

    // Once the stop bit's low half has begun the host has already seen a
    // complete frame, so inhibit there no longer aborts.
    assign abort = host_inhibit &&
                   ((state == ST_BIT_HI) ||
                    ((state == ST_BIT_LO) && (bit_idx != IDX_LAST)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            hold_dat <= '0;
            hold_vld <= 1'b0;
            pend_q   <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            pend_q   <= hold_vld | ~fifo_empty;
            busy     <= (state != ST_IDLE) | hold_vld | (fifo_count != '0);
            // Free-running half-period counter; every state change happens on
            // half_end (wrap to 0) or from a state that holds it at 0.
            half_cnt <= half_end ? '0 : half_cnt + CW'(1);

            case (state)
                ST_IDLE: begin
                    half_cnt <= '0;
                    if (start) begin
                        state    <= ST_BIT_HI;
                        bit_idx  <= '0;
                        ps2_data <= frame_w[0];
                        shreg    <= frame_w[PS2_FRAME_BITS-1:1];
                        hold_dat <= frame_src;
                        hold_vld <= 1'b1;
                    end
                end

                ST_BIT_HI: begin
                    if (abort) begin
                        state    <= ST_INHIBIT;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end else if (half_end) begin
                        state   <= ST_BIT_LO;
                        ps2_clk <= 1'b0;
                    end
                end

                ST_BIT_LO: begin
                    if (abort) begin
                        state    <= ST_INHIBIT;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end else if (half_end) begin
                        ps2_clk <= 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state    <= ST_GAP;
                            bit_idx  <= '0;
                            tx_done  <= 1'b1;
                            hold_vld <= 1'b0;
                        end else begin
                            state    <= ST_BIT_HI;
                            bit_idx  <= bit_idx + 4'd1;
                            ps2_data <= shreg[0];
                            shreg    <= {1'b1, shreg[PS2_FRAME_BITS-2:1]};
                        end
                    end
                end

                // bit_idx doubles as the gap half-period counter
                ST_GAP: begin
                    if (half_end) begin
                        if (bit_idx == GAP_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end

                ST_INHIBIT: begin
                    half_cnt <= '0;
                    if (!host_inhibit) begin
                        state   <= ST_GAP;
                        bit_idx <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx with HALF_DIV=4: a PS/2 receiver model decodes frames
// on ps2_clk falls and the scenario tasks check them against queued bytes.
module tb_ps2_kbd_tx;

    localparam int HALF_DIV   = 4;
    localparam int FIFO_DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       host_inhibit = 1'b0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_kbd_tx #(
        .HALF_DIV   (HALF_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .host_inhibit (host_inhibit),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    // ---------------- scoreboard and receiver model ----------------
    logic [7:0]  exp_q[$];
    logic [10:0] rx_q[$];
    int          gap_q[$];

    int          cyc = 0;
    int          bit_n = 0;
    int          hi_run = 0;
    int          done_cnt = 0;
    int          start_cyc = 0;
    int          fall0_cyc = 0;
    int          done_cyc = 0;
    logic        prev_clk = 1'b1;
    logic [10:0] rx_sh = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n || host_inhibit) begin
            bit_n = 0;
        end else if (prev_clk && !ps2_clk) begin
            if (bit_n == 0) fall0_cyc = cyc;
            rx_sh[bit_n] = ps2_data;
            bit_n++;
            if (bit_n == 11) begin
                rx_q.push_back(rx_sh);
                bit_n = 0;
            end
        end
        if (ps2_clk && ps2_data) begin
            hi_run++;
        end else begin
            if (ps2_clk && !ps2_data && hi_run > 0) begin
                gap_q.push_back(hi_run);
                start_cyc = cyc;
            end
            hi_run = 0;
        end
        if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_clk = ps2_clk;
    end

    // Drives one byte (in_valid left high for back-to-back use) and queues it once accepted.
    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
            #1;
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(posedge clk); t++;
        end
        #1;
        ok = (rx_q.size() >= n);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ps2_clk !== 1'b1)  begin failures++; $display("FAIL reset_ps2_clk: got %b required 1", ps2_clk); end
        checks++; if (ps2_data !== 1'b1) begin failures++; $display("FAIL reset_ps2_data: got %b required 1", ps2_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (tx_done !== 1'b0)  begin failures++; $display("FAIL reset_tx_done: got %b required 0", tx_done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        int pc;
        bit ok;
        logic [10:0] got;
        logic [7:0]  e;
        logic [10:0] want;
        push_byte(8'h1C);
        pc = cyc;
        in_valid = 1'b0;
        wait_rx(1, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: frames=%0d required 1", rx_q.size()); end
        if (ok) begin
            got = rx_q.pop_front();
            e = exp_q.pop_front();
            want = {1'b1, ~^e, e, 1'b0};
            checks++; if (got !== 11'b10000111000) begin failures++; $display("FAIL single_bits: got %b required %b", got, 11'b10000111000); end
            checks++; if (got !== want) begin failures++; $display("FAIL single_model: got %b required %b", got, want); end
        end
        repeat (2 * HALF_DIV + 6) @(posedge clk); #1;
        checks++; if (start_cyc - pc !== 2) begin failures++; $display("FAIL single_start_latency: got %0d required 2", start_cyc - pc); end
        checks++; if (fall0_cyc - pc !== 2 + HALF_DIV) begin failures++; $display("FAIL single_first_fall: got %0d required %0d", fall0_cyc - pc, 2 + HALF_DIV); end
        checks++; if (done_cyc - start_cyc !== 22 * HALF_DIV) begin failures++; $display("FAIL single_done_time: got %0d required %0d", done_cyc - start_cyc, 22 * HALF_DIV); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'hF0};
        logic       par   [3] = '{1'b1, 1'b1, 1'b1};
        bit ok;
        logic [10:0] got;
        logic [7:0]  e;
        logic [10:0] want;
        gap_q.delete();
        for (int i = 0; i < 3; i++) push_byte(bytes[i]);
        in_valid = 1'b0;
        wait_rx(3, 800, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: frames=%0d required 3", rx_q.size()); end
        for (int i = 0; i < 3 && rx_q.size() > 0; i++) begin
            got = rx_q.pop_front();
            e = exp_q.pop_front();
            want = {1'b1, ~^e, e, 1'b0};
            checks++; if (got !== want) begin failures++; $display("FAIL b2b_frame%0d: got %b required %b", i, got, want); end
            checks++; if (got[9] !== par[i]) begin failures++; $display("FAIL b2b_parity%0d: got %b required %b", i, got[9], par[i]); end
        end
        repeat (2 * HALF_DIV + 6) @(posedge clk); #1;
        checks++; if (gap_q.size() !== 3) begin failures++; $display("FAIL b2b_gap_count: got %0d required 3", gap_q.size()); end
        for (int i = 1; i < 3 && i < gap_q.size(); i++) begin
            checks++; if (gap_q[i] < 2 * HALF_DIV) begin failures++; $display("FAIL b2b_gap%0d: got %0d required >=%0d", i, gap_q[i], 2 * HALF_DIV); end
        end
    endtask

    task automatic test_fifo_full();
        int d0 = done_cnt;
        bit ok;
        logic [10:0] got;
        logic [7:0]  e;
        logic [10:0] want;
        for (int i = 0; i < 17; i++) push_byte(8'((i * 37 + 5) & 8'hFF));
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b required 1", busy); end
        in_valid = 1'b0;
        wait_rx(17, 3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_timeout: frames=%0d required 17", rx_q.size()); end
        for (int i = 0; i < 17 && rx_q.size() > 0; i++) begin
            got = rx_q.pop_front();
            e = exp_q.pop_front();
            want = {1'b1, ~^e, e, 1'b0};
            checks++; if (got !== want) begin failures++; $display("FAIL full_frame%0d: got %b required %b", i, got, want); end
        end
        repeat (2 * HALF_DIV + 6) @(posedge clk); #1;
        checks++; if (done_cnt - d0 !== 17) begin failures++; $display("FAIL full_done_count: got %0d required 17", done_cnt - d0); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after: got %b required 1", in_ready); end
    endtask

    task automatic test_inhibit_abort();
        int d0 = done_cnt;
        int t = 0;
        bit ok;
        bit bad = 0;
        logic [10:0] got;
        logic [7:0]  e;
        logic [10:0] want;
        push_byte(8'h5A);
        in_valid = 1'b0;
        while (!(bit_n == 6 && ps2_clk == 1'b0) && t < 400) begin
            @(negedge clk); #1; t++;
        end
        checks++; if (bit_n != 6) begin failures++; $display("FAIL abort_reach_idx5: bit_n=%0d required 6", bit_n); end
        host_inhibit = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin failures++; $display("FAIL abort_release: got clk=%b data=%b required 1 1", ps2_clk, ps2_data); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ({ps2_clk, ps2_data} !== 2'b11) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL abort_lines_held: got a low line required both high"); end
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL abort_no_done: got %0d required %0d", done_cnt, d0); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL abort_no_frame: got %0d required 0", rx_q.size()); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b required 1", busy); end
        host_inhibit = 1'b0;
        wait_rx(1, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_retx_timeout: frames=%0d required 1", rx_q.size()); end
        if (ok) begin
            got = rx_q.pop_front();
            e = exp_q.pop_front();
            want = {1'b1, ~^e, e, 1'b0};
            checks++; if (got !== want) begin failures++; $display("FAIL abort_retx_frame: got %b required %b", got, want); end
        end
        repeat (2 * HALF_DIV + 40) @(posedge clk); #1;
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL abort_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL abort_single_retx: got %0d extra frames required 0", rx_q.size()); end
    endtask

    task automatic test_inhibit_last();
        int d0 = done_cnt;
        int t = 0;
        logic [10:0] got;
        logic [7:0]  e;
        logic [10:0] want;
        push_byte(8'h33);
        in_valid = 1'b0;
        while (!(rx_q.size() >= 1 && ps2_clk == 1'b0) && t < 400) begin
            @(negedge clk); #1; t++;
        end
        host_inhibit = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL last_done: got %0d required 1", done_cnt - d0); end
        repeat (10) @(posedge clk); #1;
        host_inhibit = 1'b0;
        repeat (150) @(posedge clk); #1;
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL last_frame_count: got %0d required 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            e = exp_q.pop_front();
            want = {1'b1, ~^e, e, 1'b0};
            checks++; if (got !== want) begin failures++; $display("FAIL last_frame: got %b required %b", got, want); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL last_no_retx: got %0d required 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL last_busy: got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int t = 0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        in_valid = 1'b0;
        while (bit_n != 3 && t < 400) begin
            @(negedge clk); #1; t++;
        end
        reset_n = 1'b0;
        #1;
        checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin failures++; $display("FAIL rst_lines: got clk=%b data=%b required 1 1", ps2_clk, ps2_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        exp_q.delete();
        rx_q.delete();
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (300) @(posedge clk); #1;
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL rst_no_tx: got %0d frames required 0", rx_q.size()); end
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL rst_no_done: got %0d required %0d", done_cnt, d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_after: got %b required 0", busy); end
        checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin failures++; $display("FAIL rst_lines_after: got clk=%b data=%b required 1 1", ps2_clk, ps2_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_inhibit_abort();
        test_inhibit_last();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
